// File: rtl/pulse_dispenser.sv
// pulse_dispenser: replays a loaded count as a train of single-cycle step
// pulses, each tagged with a direction, with GAP idle cycles between pulses.
// Load handshake: a job is accepted on any rising edge where
// in_valid && in_ready. in_ready is high only in IDLE. There is no buffering,
// so the source holds in_valid (and its data) until it sees in_ready.
// done strobes for one cycle at the end of every accepted job.
// Optional feature macro: PULSE_DISPENSER_ABORT_EN adds an abort input that
// ends a running job early.
// All outputs are decoded from registered state only (Moore).
module pulse_dispenser #(
  parameter int WIDTH = 6,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  input  logic             in_dir,
`ifdef PULSE_DISPENSER_ABORT_EN
  input  logic             abort,
`endif
  output logic             in_ready,
  output logic             pulse_out,
  output logic             pulse_dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero gap means the PULSE state repeats directly without visiting GAP.
  localparam bit       NO_GAP     = (GAP == 0);
  localparam logic [7:0] GAP_RELOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           r_state;
  logic [WIDTH-1:0] r_remaining;
  logic             r_dir;
  logic [7:0]       r_gap_cnt;
  logic             w_abort;

`ifdef PULSE_DISPENSER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Job sequencer: load, emit pulses with gap spacing, strobe done, return to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_gap_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_remaining <= in_count;
            r_dir       <= in_dir;
            r_state     <= (in_count == '0) ? S_DONE : S_PULSE;
          end
        end
        S_PULSE: begin
          // The pulse in this cycle is delivered even if aborted, so always count it.
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == WIDTH'(1) || w_abort) begin
            r_state <= S_DONE;
          end else if (NO_GAP) begin
            r_state <= S_PULSE;
          end else begin
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_RELOAD;
          end
        end
        S_GAP: begin
          if (w_abort) begin
            r_state <= S_DONE;
          end else if (r_gap_cnt == 8'd0) begin
            r_state <= S_PULSE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign pulse_out   = (r_state == S_PULSE);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign pulse_dir   = r_dir;
  assign remaining   = r_remaining;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pulse_dispenser.sv
// Testbench for pulse_dispenser: directed scenarios against two instances,
// u0 with GAP=1 and u1 with GAP=0, both WIDTH=6.
module tb_pulse_dispenser;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid0 = 1'b0;
  logic [W-1:0] in_count0 = '0;
  logic         in_dir0   = 1'b0;
  logic         in_ready0, pulse_out0, pulse_dir0, busy0, done0;
  logic [W-1:0] remaining0;
  logic [1:0]   dbg_state0;

  logic         in_valid1 = 1'b0;
  logic [W-1:0] in_count1 = '0;
  logic         in_dir1   = 1'b0;
  logic         in_ready1, pulse_out1, pulse_dir1, busy1, done1;
  logic [W-1:0] remaining1;
  logic [1:0]   dbg_state1;

`ifdef PULSE_DISPENSER_ABORT_EN
  logic         abort0 = 1'b0;
  logic         abort1 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Clock and reset
  always #5 clk = ~clk;

  pulse_dispenser #(.WIDTH(W), .GAP(1)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_count(in_count0), .in_dir(in_dir0),
`ifdef PULSE_DISPENSER_ABORT_EN
    .abort(abort0),
`endif
    .in_ready(in_ready0), .pulse_out(pulse_out0), .pulse_dir(pulse_dir0),
    .busy(busy0), .done(done0), .remaining(remaining0), .o_dbg_state(dbg_state0)
  );

  pulse_dispenser #(.WIDTH(W), .GAP(0)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_count(in_count1), .in_dir(in_dir1),
`ifdef PULSE_DISPENSER_ABORT_EN
    .abort(abort1),
`endif
    .in_ready(in_ready1), .pulse_out(pulse_out1), .pulse_dir(pulse_dir1),
    .busy(busy1), .done(done1), .remaining(remaining1), .o_dbg_state(dbg_state1)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || pulse_out0 !== 1'b0 ||
          done0 !== 1'b0 || pulse_dir0 !== 1'b0 || remaining0 !== 6'd0) begin
        bad++;
        $display("FAIL reset_u0 cyc=%0d got rdy=%b busy=%b pls=%b done=%b dir=%b rem=%0d want 1 0 0 0 0 0",
                 c, in_ready0, busy0, pulse_out0, done0, pulse_dir0, remaining0);
      end
      total++;
      if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || pulse_out1 !== 1'b0 ||
          done1 !== 1'b0 || pulse_dir1 !== 1'b0 || remaining1 !== 6'd0) begin
        bad++;
        $display("FAIL reset_u1 cyc=%0d got rdy=%b busy=%b pls=%b done=%b dir=%b rem=%0d want 1 0 0 0 0 0",
                 c, in_ready1, busy1, pulse_out1, done1, pulse_dir1, remaining1);
      end
      step();
    end
  endtask

  // Three pulses, GAP=1: pulses on cycles 1,3,5, done on 6, ready on 7.
  task automatic test_load3();
    logic       exp_pls [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_done[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_busy[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] exp_rem [7] = '{6'd3, 6'd2, 6'd2, 6'd1, 6'd1, 6'd0, 6'd0};
    in_valid0 = 1'b1;
    in_count0 = 6'd3;
    in_dir0   = 1'b1;
    step();
    in_valid0 = 1'b0;
    in_dir0   = 1'b0;
    for (int c = 0; c < 7; c++) begin
      total++;
      if (pulse_out0 !== exp_pls[c] || done0 !== exp_done[c] || busy0 !== exp_busy[c] ||
          in_ready0 !== ~exp_busy[c] || remaining0 !== exp_rem[c] || pulse_dir0 !== 1'b1) begin
        bad++;
        $display("FAIL load3 cyc=%0d got pls=%b done=%b busy=%b rdy=%b rem=%0d dir=%b want %b %b %b %b %0d 1",
                 c + 1, pulse_out0, done0, busy0, in_ready0, remaining0, pulse_dir0,
                 exp_pls[c], exp_done[c], exp_busy[c], ~exp_busy[c], exp_rem[c]);
      end
      step();
    end
  endtask

  // Maximum count with GAP=0: 63 consecutive pulses, done on 64, no wrap.
  task automatic test_gap0_max();
    int pulses = 0;
    in_valid1 = 1'b1;
    in_count1 = 6'd63;
    in_dir1   = 1'b0;
    step();
    in_valid1 = 1'b0;
    for (int c = 1; c <= 63; c++) begin
      if (pulse_out1 === 1'b1) pulses++;
      total++;
      if (pulse_out1 !== 1'b1 || remaining1 !== 6'(64 - c) || done1 !== 1'b0) begin
        bad++;
        $display("FAIL gap0_pulse cyc=%0d got pls=%b rem=%0d done=%b want 1 %0d 0",
                 c, pulse_out1, remaining1, done1, 64 - c);
      end
      step();
    end
    total++;
    if (done1 !== 1'b1 || pulse_out1 !== 1'b0 || remaining1 !== 6'd0 || in_ready1 !== 1'b0) begin
      bad++;
      $display("FAIL gap0_done got done=%b pls=%b rem=%0d rdy=%b want 1 0 0 0",
               done1, pulse_out1, remaining1, in_ready1);
    end
    step();
    for (int c = 0; c < 3; c++) begin
      if (pulse_out1 === 1'b1) pulses++;
      total++;
      if (in_ready1 !== 1'b1 || remaining1 !== 6'd0 || busy1 !== 1'b0) begin
        bad++;
        $display("FAIL gap0_after cyc=%0d got rdy=%b rem=%0d busy=%b want 1 0 0",
                 c, in_ready1, remaining1, busy1);
      end
      step();
    end
    total++;
    if (pulses !== 63) begin
      bad++;
      $display("FAIL gap0_count got %0d pulses want 63", pulses);
    end
  endtask

  // Zero count: DONE only, busy for exactly one cycle, no pulses.
  task automatic test_zero();
    int busy_cycles = 0;
    int pulses = 0;
    in_valid0 = 1'b1;
    in_count0 = 6'd0;
    step();
    in_valid0 = 1'b0;
    total++;
    if (done0 !== 1'b1 || busy0 !== 1'b1 || pulse_out0 !== 1'b0) begin
      bad++;
      $display("FAIL zero_done got done=%b busy=%b pls=%b want 1 1 0", done0, busy0, pulse_out0);
    end
    for (int c = 0; c < 4; c++) begin
      if (busy0 === 1'b1) busy_cycles++;
      if (pulse_out0 === 1'b1) pulses++;
      step();
    end
    total++;
    if (busy_cycles !== 1 || pulses !== 0 || in_ready0 !== 1'b1) begin
      bad++;
      $display("FAIL zero_len got busy_cycles=%0d pulses=%0d rdy=%b want 1 0 1",
               busy_cycles, pulses, in_ready0);
    end
  endtask

  // in_valid held through a 2-pulse job with new data: taken only once IDLE.
  // Then reset during the GAP of the 5-pulse job abandons it silently.
  task automatic test_hold_valid_and_reset();
    logic [5:0] exp_rem[4] = '{6'd2, 6'd1, 6'd1, 6'd0};
    int pulses = 0;
    int events = 0;
    in_valid0 = 1'b1;
    in_count0 = 6'd2;
    in_dir0   = 1'b0;
    step();
    in_count0 = 6'd5;
    in_dir0   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (pulse_out0 === 1'b1) pulses++;
      total++;
      if (remaining0 !== exp_rem[c] || pulse_dir0 !== 1'b0 || in_ready0 !== 1'b0) begin
        bad++;
        $display("FAIL hold_first cyc=%0d got rem=%0d dir=%b rdy=%b want %0d 0 0",
                 c + 1, remaining0, pulse_dir0, in_ready0, exp_rem[c]);
      end
      step();
    end
    total++;
    if (pulses !== 2 || in_ready0 !== 1'b1 || remaining0 !== 6'd0) begin
      bad++;
      $display("FAIL hold_idle got pulses=%0d rdy=%b rem=%0d want 2 1 0", pulses, in_ready0, remaining0);
    end
    step();
    in_valid0 = 1'b0;
    total++;
    if (pulse_out0 !== 1'b1 || remaining0 !== 6'd5 || pulse_dir0 !== 1'b1) begin
      bad++;
      $display("FAIL hold_second got pls=%b rem=%0d dir=%b want 1 5 1", pulse_out0, remaining0, pulse_dir0);
    end
    step();
    total++;
    if (dbg_state0 !== 2'd2 || busy0 !== 1'b1 || pulse_out0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_pre got state=%0d busy=%b pls=%b want 2 1 0", dbg_state0, busy0, pulse_out0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (pulse_out0 === 1'b1 || done0 === 1'b1) events++;
      total++;
      if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || remaining0 !== 6'd0 || pulse_dir0 !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got rdy=%b busy=%b rem=%0d dir=%b want 1 0 0 0",
                 c, in_ready0, busy0, remaining0, pulse_dir0);
      end
      step();
    end
    total++;
    if (events !== 0) begin
      bad++;
      $display("FAIL reset_mid_events got %0d pulse/done cycles want 0", events);
    end
  endtask

`ifdef PULSE_DISPENSER_ABORT_EN
  // Load 10, abort during the 4th pulse (cycle 7): 4 pulses, done on 8, remaining 6.
  task automatic test_abort();
    int pulses = 0;
    abort0 = 1'b1;
    step();
    total++;
    if (in_ready0 !== 1'b1 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got rdy=%b done=%b want 1 0", in_ready0, done0);
    end
    abort0    = 1'b0;
    in_valid0 = 1'b1;
    in_count0 = 6'd10;
    in_dir0   = 1'b0;
    step();
    in_valid0 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (pulse_out0 === 1'b1) pulses++;
      if (c == 7) abort0 = 1'b1;
      step();
    end
    abort0 = 1'b0;
    total++;
    if (pulses !== 4 || done0 !== 1'b1 || pulse_out0 !== 1'b0 || remaining0 !== 6'd6) begin
      bad++;
      $display("FAIL abort_done got pulses=%0d done=%b pls=%b rem=%0d want 4 1 0 6",
               pulses, done0, pulse_out0, remaining0);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (pulse_out0 !== 1'b0 || in_ready0 !== 1'b1 || remaining0 !== 6'd6) begin
        bad++;
        $display("FAIL abort_after cyc=%0d got pls=%b rdy=%b rem=%0d want 0 1 6",
                 c, pulse_out0, in_ready0, remaining0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load3();
    test_gap0_max();
    test_zero();
    test_hold_valid_and_reset();
`ifdef PULSE_DISPENSER_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
